// File: rtl/shift_arb_seq.sv
// Two-requester logical shift sequencer: round-robin picks a job, then one narrow
// shifter moves it at most STEP bits per clock and holds the result until it is taken.
module shift_arb_seq #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5,
    parameter int STEP  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [AMT_W-1:0] req0_amt,
    input  logic             req0_dir,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [AMT_W-1:0] req1_amt,
    input  logic             req1_dir,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,
    output logic             res_sticky,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    localparam logic [AMT_W-1:0] STEP_A = AMT_W'(STEP);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic             dir_q, dir_d;
    logic             id_q, id_d;
    logic             sticky_q, sticky_d;
    logic             last_q, last_d;

    logic             grant0, grant1;
    logic [WIDTH-1:0] sh_data;
    logic             sh_sticky;
    logic [AMT_W-1:0] step_k;

    // last_q holds the most recently granted requester; the other one wins a tie.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == IDLE) begin
            grant0 = req0_valid && (!req1_valid || last_q);
            grant1 = req1_valid && (!req0_valid || !last_q);
        end
    end

    // One clock's worth of shifting: up to STEP single-bit moves, collecting lost bits.
    always_comb begin
        sh_data   = data_q;
        sh_sticky = sticky_q;
        for (int i = 0; i < STEP; i++) begin
            if (AMT_W'(i) < rem_q) begin
                if (dir_q) begin
                    sh_sticky = sh_sticky | sh_data[0];
                    sh_data   = sh_data >> 1;
                end else begin
                    sh_sticky = sh_sticky | sh_data[WIDTH-1];
                    sh_data   = sh_data << 1;
                end
            end
        end
        step_k = (rem_q < STEP_A) ? rem_q : STEP_A;
    end

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        rem_d    = rem_q;
        dir_d    = dir_q;
        id_d     = id_q;
        sticky_d = sticky_q;
        last_d   = last_q;
        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    id_d     = grant1;
                    last_d   = grant1;
                    data_d   = grant1 ? req1_data : req0_data;
                    rem_d    = grant1 ? req1_amt  : req0_amt;
                    dir_d    = grant1 ? req1_dir  : req0_dir;
                    sticky_d = 1'b0;
                    state_d  = ((grant1 ? req1_amt : req0_amt) == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                data_d   = sh_data;
                sticky_d = sh_sticky;
                rem_d    = rem_q - step_k;
                if (rem_q == step_k) state_d = DONE;
            end
            DONE: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            data_q   <= '0;
            rem_q    <= '0;
            dir_q    <= 1'b0;
            id_q     <= 1'b0;
            sticky_q <= 1'b0;
            last_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            rem_q    <= rem_d;
            dir_q    <= dir_d;
            id_q     <= id_d;
            sticky_q <= sticky_d;
            last_q   <= last_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign res_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign res_data   = data_q;
    assign res_id     = id_q;
    assign res_sticky = sticky_q;

endmodule
